// File: rtl/pc_fetch_unit.sv
// =============================================================================
// pc_fetch_unit : IF-stage PC and next-PC sequencer with a stall-time redirect buffer
// Revision      : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        keep,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] inst_addr,
  output logic [31:0] pc_plus4,
  output logic        flush_if_id,
  output logic [31:0] epc,
  output logic        pend_valid
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Larger value means higher priority, so pend arbitration is a plain compare.
  localparam logic [1:0] PRI_NONE   = 2'd0;
  localparam logic [1:0] PRI_JUMP   = 2'd1;
  localparam logic [1:0] PRI_BRANCH = 2'd2;
  localparam logic [1:0] PRI_JR     = 2'd3;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pend_target;
  logic [31:0] pend_target_next;
  logic [1:0]  pend_pri;
  logic [1:0]  pend_pri_next;
  logic        epc_load;
  logic        flush_raw;

  logic        irq_live;
  logic        trap;
  logic [31:0] trap_vec;
  logic [1:0]  req_pri;
  logic [31:0] req_target;
  logic        unused_target_bits;

  assign inst_addr  = pc;
  assign pc_plus4   = {pc[31], pc[30:0] + 31'd4};
  assign pend_valid = (state == ST_HOLD);

  // Kernel mode (pc[31]=1) masks the interrupt; exceptions always get through.
  assign irq_live = irq & ~pc[31];
  assign trap     = exc | irq_live;
  assign trap_vec = exc ? XADR_VEC : ILLOP_VEC;

  // Jump/branch targets inherit the current mode bit; jr may switch modes.
  always_comb begin
    req_pri    = PRI_NONE;
    req_target = pc_plus4;
    if (jr_en) begin
      req_pri    = PRI_JR;
      req_target = {jr_target[31:2], 2'b00};
    end else if (branch_taken) begin
      req_pri    = PRI_BRANCH;
      req_target = {pc[31], branch_target[30:2], 2'b00};
    end else if (jump_en) begin
      req_pri    = PRI_JUMP;
      req_target = {pc[31], jump_target[30:2], 2'b00};
    end
  end

  assign unused_target_bits = ^{jump_target[31], jump_target[1:0],
                                branch_target[31], branch_target[1:0],
                                jr_target[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_VEC;
      epc         <= 32'h0000_0000;
      pend_target <= 32'h0000_0000;
      pend_pri    <= PRI_NONE;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pend_target <= pend_target_next;
      pend_pri    <= pend_pri_next;
      if (epc_load) begin
        epc <= pc_plus4;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (!trap && keep && (req_pri != PRI_NONE)) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (trap || !keep) begin
          state_next = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    pc_next          = pc;
    pend_target_next = pend_target;
    pend_pri_next    = pend_pri;
    epc_load         = 1'b0;
    flush_raw        = 1'b0;
    if (trap) begin
      // Traps ignore keep and discard anything buffered.
      pc_next       = trap_vec;
      epc_load      = 1'b1;
      flush_raw     = 1'b1;
      pend_pri_next = PRI_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          if (!keep) begin
            pc_next   = req_target;
            flush_raw = (req_pri != PRI_NONE);
          end else if (req_pri != PRI_NONE) begin
            pend_target_next = req_target;
            pend_pri_next    = req_pri;
          end
        end
        ST_HOLD: begin
          if (!keep) begin
            pc_next       = (req_pri > pend_pri) ? req_target : pend_target;
            flush_raw     = 1'b1;
            pend_pri_next = PRI_NONE;
          end else if ((req_pri != PRI_NONE) && (req_pri >= pend_pri)) begin
            pend_target_next = req_target;
            pend_pri_next    = req_pri;
          end
        end
      endcase
    end
    flush_if_id = flush_raw & ~reset;
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// =============================================================================
// tb_pc_fetch_unit : directed vector table, reset corner cases and randomized model check
// Revision         : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pc_fetch_unit;

  typedef struct {
    logic        keep;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        irq;
    logic        exc;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic [31:0] exp_epc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        keep;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        irq;
  logic        exc;
  logic [31:0] inst_addr;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic [31:0] epc;
  logic        pend_valid;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_pend;
  int          m_rank;
  logic [31:0] m_ptgt;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .keep          (keep),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .irq           (irq),
    .exc           (exc),
    .inst_addr     (inst_addr),
    .pc_plus4      (pc_plus4),
    .flush_if_id   (flush_if_id),
    .epc           (epc),
    .pend_valid    (pend_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] seq4(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic vec_t mk(input logic k, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt,
                              input logic r, input logic [31:0] rt,
                              input logic iq, input logic ex,
                              input logic ef, input logic [31:0] ep,
                              input logic epv, input logic [31:0] ee);
    vec_t v;
    v.keep = k; v.jump_en = j; v.jump_target = jt;
    v.branch_taken = b; v.branch_target = bt;
    v.jr_en = r; v.jr_target = rt; v.irq = iq; v.exc = ex;
    v.exp_flush = ef; v.exp_pc = ep; v.exp_pend = epv; v.exp_epc = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    keep = v.keep; jump_en = v.jump_en; jump_target = v.jump_target;
    branch_taken = v.branch_taken; branch_target = v.branch_target;
    jr_en = v.jr_en; jr_target = v.jr_target; irq = v.irq; exc = v.exc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Behavioural model: resolve the winning request by rank, then apply the stall rules.
  task automatic model_step(input vec_t v, output logic f);
    int          rank;
    logic [31:0] tgt;
    logic        trap;
    rank = 0;
    tgt  = seq4(m_pc);
    if (v.jump_en)      begin rank = 1; tgt = {m_pc[31], v.jump_target[30:2], 2'b00}; end
    if (v.branch_taken) begin rank = 2; tgt = {m_pc[31], v.branch_target[30:2], 2'b00}; end
    if (v.jr_en)        begin rank = 3; tgt = {v.jr_target[31:2], 2'b00}; end
    trap = v.exc || (v.irq && !m_pc[31]);
    f = 1'b0;
    if (trap) begin
      f      = 1'b1;
      m_epc  = seq4(m_pc);
      m_pc   = v.exc ? 32'h8000_0008 : 32'h8000_0004;
      m_pend = 0;
    end else if (!v.keep) begin
      if (m_pend && m_rank >= rank) begin
        m_pc = m_ptgt;
        f    = 1'b1;
      end else begin
        m_pc = tgt;
        f    = (rank > 0);
      end
      m_pend = 0;
    end else if (rank > 0 && (!m_pend || rank >= m_rank)) begin
      m_pend = 1;
      m_rank = rank;
      m_ptgt = tgt;
    end
  endtask

  vec_t idle;
  vec_t v;
  logic ef;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //            k  j  jt            b  bt            r  rt            iq ex  ef pc            pend epc
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h8000_0004, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h8000_0008, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h8000_000C, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h8000_0010, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0040_0013, 0, 0,  1, 32'h0040_0010, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0040_0999, 1, 32'h8040_0101, 0, 0,            0, 0,  1, 32'h0040_0100, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h0040_0104, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0040_0200, 0, 0,            0, 0,            0, 0,  0, 32'h0040_0104, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h0040_0104, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h0040_0104, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  1, 32'h0040_0200, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h0040_0204, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0040_0300, 0, 0,            0, 0,            0, 0,  0, 32'h0040_0204, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0,            0, 0,            0, 0,            0, 1,  1, 32'h8000_0008, 0, 32'h0040_0208));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h8000_000C, 0, 32'h0040_0208));
    vecs.push_back(mk(1, 0, 0,            0, 0,            1, 32'h0000_0700, 0, 0,  0, 32'h8000_000C, 1, 32'h0040_0208));
    vecs.push_back(mk(1, 0, 0,            1, 32'h0000_0500, 0, 0,            0, 0,  0, 32'h8000_000C, 1, 32'h0040_0208));
    vecs.push_back(mk(1, 0, 0,            0, 0,            1, 32'h0000_0704, 0, 0,  0, 32'h8000_000C, 1, 32'h0040_0208));
    vecs.push_back(mk(0, 1, 32'h0000_0800, 0, 0,            0, 0,            0, 0,  1, 32'h0000_0704, 0, 32'h0040_0208));
    vecs.push_back(mk(1, 0, 0,            0, 0,            0, 0,            1, 0,  1, 32'h8000_0004, 0, 32'h0000_0708));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h8000_0040, 0, 0,  1, 32'h8000_0040, 0, 32'h0000_0708));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            1, 0,  0, 32'h8000_0044, 0, 32'h0000_0708));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0040_0000, 0, 0,  1, 32'h0040_0000, 0, 32'h0000_0708));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            1, 0,  1, 32'h8000_0004, 0, 32'h0040_0004));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h7FFF_FFFC, 0, 0,  1, 32'h7FFF_FFFC, 0, 32'h0040_0004));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h0000_0000, 0, 32'h0040_0004));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'hFFFF_FFFF, 0, 0,  1, 32'hFFFF_FFFC, 0, 32'h0040_0004));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            0, 0,  0, 32'h8000_0000, 0, 32'h0040_0004));
    vecs.push_back(mk(1, 1, 32'h0000_0100, 0, 0,            0, 0,            0, 0,  0, 32'h8000_0000, 1, 32'h0040_0004));
    vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0000_0200, 0, 0,  1, 32'h0000_0200, 0, 32'h0040_0004));
    vecs.push_back(mk(0, 0, 0,            0, 0,            0, 0,            1, 1,  1, 32'h8000_0008, 0, 32'h0000_0204));

    // Reset state
    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.inst_addr", inst_addr, 32'h8000_0000);
    chk("reset.pc_plus4", pc_plus4, 32'h8000_0004);
    chk("reset.epc", epc, 32'h0);
    chk("reset.pend_valid", {31'b0, pend_valid}, 32'h0);
    chk("reset.flush", {31'b0, flush_if_id}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d.flush", i), {31'b0, flush_if_id}, {31'b0, vecs[i].exp_flush});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.inst_addr", i), inst_addr, vecs[i].exp_pc);
      chk($sformatf("vec%0d.pc_plus4", i), pc_plus4, seq4(vecs[i].exp_pc));
      chk($sformatf("vec%0d.epc", i), epc, vecs[i].exp_epc);
      chk($sformatf("vec%0d.pend_valid", i), {31'b0, pend_valid}, {31'b0, vecs[i].exp_pend});
    end

    // Reset asserted while a jump is buffered
    drive(mk(1, 1, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("hold.pend_valid", {31'b0, pend_valid}, 32'h1);
    drive(mk(0, 0, 0, 0, 0, 1, 32'h0000_1234, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #1;
    chk("rst_hold.inst_addr", inst_addr, 32'h8000_0000);
    chk("rst_hold.pend_valid", {31'b0, pend_valid}, 32'h0);
    chk("rst_hold.flush", {31'b0, flush_if_id}, 32'h0);
    chk("rst_hold.epc", epc, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold.held_pc", inst_addr, 32'h8000_0000);
    reset = 1'b0;
    drive(idle);
    #2;
    chk("post_rst.flush", {31'b0, flush_if_id}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst.inst_addr", inst_addr, 32'h8000_0004);
    chk("post_rst.pend_valid", {31'b0, pend_valid}, 32'h0);

    // Randomized run against the behavioural model
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_pc = 32'h8000_0000; m_epc = 32'h0; m_pend = 0; m_rank = 0; m_ptgt = 32'h0;
    for (int n = 0; n < 600; n++) begin
      v = idle;
      v.keep          = ($urandom_range(0, 99) < 40);
      v.jump_en       = ($urandom_range(0, 99) < 25);
      v.jump_target   = $urandom;
      v.branch_taken  = ($urandom_range(0, 99) < 15);
      v.branch_target = $urandom;
      v.jr_en         = ($urandom_range(0, 99) < 10);
      v.jr_target     = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h8000_0000) : ($urandom & 32'h7FFF_FFFF);
      v.irq           = ($urandom_range(0, 99) < 10);
      v.exc           = ($urandom_range(0, 99) < 4);
      drive(v);
      model_step(v, ef);
      #2;
      chk($sformatf("rnd%0d.flush", n), {31'b0, flush_if_id}, {31'b0, ef});
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d.inst_addr", n), inst_addr, m_pc);
      chk($sformatf("rnd%0d.pc_plus4", n), pc_plus4, seq4(m_pc));
      chk($sformatf("rnd%0d.epc", n), epc, m_epc);
      chk($sformatf("rnd%0d.pend_valid", n), {31'b0, pend_valid}, {31'b0, m_pend});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
